masked_case_lut: RTL and testbench
==================================

# masked_case_lut

Parametrised, registered masked-case lookup unit: a programmable table of ENTRIES (match, care, value) rows, a global key mask, and first-match priority resolution. It replaces hand-written combinational `case (key & MASK)` decoders in the regression designs. Each table row and the key mask are reloadable at run time. Lookups are pipelined with a valid flag, and a mode selects either hold-last-value on a miss (latch-like case semantics) or a default value.

## Interface
- KEY_W, 4, key width in bits (≥1)
- VAL_W, 3, result width in bits (≥1)
- ENTRIES, 8, table rows (≥1); IDX_W = max(1, $clog2(ENTRIES))
- HOLD_ON_MISS, 1, 1 = miss keeps previous out_value; 0 = miss returns DEFAULT_VAL
- DEFAULT_VAL, 0, miss result when HOLD_ON_MISS=0; also reset value of the held result
- clk  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high
- cfg_we  input  1  write table row cfg_idx this cycle
- cfg_idx  input  IDX_W  row address; writes with cfg_idx ≥ ENTRIES are ignored
- cfg_en  input  1  row enable written with the row
- cfg_match  input  KEY_W  row match pattern
- cfg_care  input  KEY_W  per-bit care mask (1 = compare bit)
- cfg_value  input  VAL_W  row result
- kmask_we  input  1  load global key mask
- kmask_in  input  KEY_W  new global key mask
- in_valid  input  1  lookup request
- in_key  input  KEY_W  lookup key
- out_valid  output  1  result valid
- out_value  output  VAL_W  result
- out_hit  output  1  some enabled row matched
- out_idx  output  IDX_W  lowest matching row index; 0 on miss

## Operation
- Effective key: k = in_key & kmask.
- Row r matches when en[r] && ((k ^ match[r]) & care[r]) == 0. A row with care = 0 matches every key.
- Priority: the lowest-index matching row wins.
- Hit: out_value = value[winner], out_hit = 1, out_idx = winner.
- Miss, HOLD_ON_MISS=1: out_value = held result; out_hit = 0; out_idx = 0.
- Miss, HOLD_ON_MISS=0: out_value = DEFAULT_VAL; out_hit = 0; out_idx = 0.
- Held result register: updated only on a valid hit, to that hit's value. Misses and invalid cycles leave it unchanged.
- No backpressure: every in_valid produces exactly one out_valid. Back-to-back requests are accepted every cycle.
- Reset state:
  - all rows: en = 0, match = 0, care = 0, value = 0
  - kmask = all ones
  - held result = DEFAULT_VAL
  - out_valid = 0, out_value = DEFAULT_VAL, out_hit = 0, out_idx = 0

## Timing
- Latency 2 cycles. in_valid at edge T gives out_valid high during the cycle after edge T+2.
- Stage 1: registers k and the per-row match vector.
- Stage 2: registers priority resolution, the value mux and the held-result update.
- Outputs are registered. When out_valid = 0, out_value/out_hit/out_idx keep their last values.
- Config visibility:
  - A cfg_we or kmask_we at edge T is seen by lookups sampled at edge T+1 or later.
  - A lookup sampled at edge T uses the pre-write table, including when the write targets the matching row in the same cycle.
- Simultaneous cfg_we and kmask_we: both take effect.
- Back-to-back hold: a miss at T+1 directly after a hit at T outputs the hit-at-T value (held-result forwarding inside stage 2).
- Reset asserted mid-flight: both pipeline stages are dropped, so no out_valid appears for requests sampled before reset deasserts. Table and mask return to reset values.
- in_valid during reset is ignored.

## Structure
- Shared package masked_case_pkg:
  - entry typedef (en, match, care, value)
  - IDX_W helper function
  - reset constants for kmask and entry
- Sub-module masked_case_row: one row's register and its combinational match bit, instantiated ENTRIES times via generate.
- Top level holds kmask, the pipeline registers and the priority encoder.

## Test plan
- Case-decode equivalence: load rows 0..7 with match {0,2,4,6,8,a,c,e}, care 4'hF, value 7-r; kmask = 4'b1110; in_key = i<<1 (and i<<1|1) for i = 0..7 -> out_value = 7-i, out_hit = 1, out_idx = i, 2-cycle latency.
- Hold vs default: rows only for keys 0 and 2; stream 0, 5, 2, 9:
  - HOLD_ON_MISS=1 -> values 7, 7, 6, 6 with out_hit 1, 0, 1, 0
  - HOLD_ON_MISS=0, DEFAULT_VAL=3 -> 7, 3, 6, 3
- Priority and wildcards: row 1 care=0 value 5, row 4 exact key 4'h4 value 2 -> key 4 gives 5, idx 1; disabling row 1 gives 2, idx 4.
- Write/lookup collision: in the same cycle, rewrite row 0's value 7 -> 1 and look up key 0 -> old value 7. The next lookup gives 1.
- Reset mid-flight: issue 2 back-to-back lookups, assert reset for 1 cycle on the following edge -> no out_valid. Afterwards a lookup misses with out_value = DEFAULT_VAL and kmask = all ones.
- Parameter sweep KEY_W=8, VAL_W=5, ENTRIES=3: cfg_idx 3 write ignored; random keys checked against a reference model for 1000 cycles.

Source files
------------

// File: rtl/masked_case_pkg.sv
// Shared definitions for the masked-case lookup unit: reset constants,
// miss-policy encoding and the index-width helper.
package masked_case_pkg;

  localparam logic ROW_EN_RST    = 1'b0;
  localparam logic KMASK_BIT_RST = 1'b1;

  typedef enum logic {
    MISS_DEFAULT = 1'b0,
    MISS_HOLD    = 1'b1
  } miss_mode_e;

  function automatic int unsigned idx_width(input int unsigned entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

endpackage

// File: rtl/masked_case_row.sv
// One programmable table row: (en, match, care, value) register plus its
// combinational match bit against the effective key.
module masked_case_row
  import masked_case_pkg::*;
#(
  parameter int unsigned KEY_W = 4,
  parameter int unsigned VAL_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic             en_i,
  input  logic [KEY_W-1:0] match_i,
  input  logic [KEY_W-1:0] care_i,
  input  logic [VAL_W-1:0] value_i,
  input  logic [KEY_W-1:0] key_i,
  output logic             hit_o,
  output logic [VAL_W-1:0] value_o
);

  typedef struct packed {
    logic             en;
    logic [KEY_W-1:0] match;
    logic [KEY_W-1:0] care;
    logic [VAL_W-1:0] value;
  } entry_t;

  localparam entry_t ENTRY_RST = '{en: ROW_EN_RST, match: '0, care: '0, value: '0};

  entry_t entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (we_i) begin
      entry_d = '{en: en_i, match: match_i, care: care_i, value: value_i};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entry_q <= ENTRY_RST;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign hit_o   = entry_q.en && (((key_i ^ entry_q.match) & entry_q.care) == '0);
  assign value_o = entry_q.value;

endmodule

// File: rtl/masked_case_lut.sv
// Registered masked-case lookup: programmable rows, global key mask,
// lowest-index-wins priority, hold-or-default miss policy.
module masked_case_lut
  import masked_case_pkg::*;
#(
  parameter int unsigned       KEY_W        = 4,
  parameter int unsigned       VAL_W        = 3,
  parameter int unsigned       ENTRIES      = 8,
  parameter int unsigned       HOLD_ON_MISS = 1,
  parameter logic [VAL_W-1:0]  DEFAULT_VAL  = '0,
  parameter int unsigned       IDX_W        = idx_width(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic             cfg_en,
  input  logic [KEY_W-1:0] cfg_match,
  input  logic [KEY_W-1:0] cfg_care,
  input  logic [VAL_W-1:0] cfg_value,
  input  logic             kmask_we,
  input  logic [KEY_W-1:0] kmask_in,
  input  logic             in_valid,
  input  logic [KEY_W-1:0] in_key,
  output logic             out_valid,
  output logic [VAL_W-1:0] out_value,
  output logic             out_hit,
  output logic [IDX_W-1:0] out_idx
);

  localparam miss_mode_e MISS_MODE = (HOLD_ON_MISS != 0) ? MISS_HOLD : MISS_DEFAULT;

  logic [KEY_W-1:0]   kmask_q, kmask_d;
  logic [KEY_W-1:0]   key_eff;
  logic [ENTRIES-1:0] row_hit;
  logic [VAL_W-1:0]   row_value [ENTRIES];

  logic               s1_valid_q;
  logic [ENTRIES-1:0] s1_hit_q;
  logic [VAL_W-1:0]   s1_value_q [ENTRIES];

  logic               s2_valid_q;
  logic               s2_hit_q, s2_hit_d;
  logic [IDX_W-1:0]   s2_idx_q, s2_idx_d;
  logic [VAL_W-1:0]   s2_value_q, s2_value_d;
  logic [VAL_W-1:0]   held_q, held_d;
  logic [VAL_W-1:0]   win_value;
  logic               found;

  logic               out_valid_q, out_hit_q;
  logic [IDX_W-1:0]   out_idx_q;
  logic [VAL_W-1:0]   out_value_q;

  assign kmask_d = kmask_we ? kmask_in : kmask_q;
  assign key_eff = in_key & kmask_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      kmask_q <= {KEY_W{KMASK_BIT_RST}};
    end else begin
      kmask_q <= kmask_d;
    end
  end

  // Out-of-range cfg_idx matches no row, so such writes fall away.
  for (genvar r = 0; r < ENTRIES; r++) begin : g_row
    masked_case_row #(
      .KEY_W (KEY_W),
      .VAL_W (VAL_W)
    ) u_row (
      .clk     (clk),
      .reset   (reset),
      .we_i    (cfg_we && (cfg_idx == IDX_W'(r))),
      .en_i    (cfg_en),
      .match_i (cfg_match),
      .care_i  (cfg_care),
      .value_i (cfg_value),
      .key_i   (key_eff),
      .hit_o   (row_hit[r]),
      .value_o (row_value[r])
    );
  end

  // Row values are snapshotted alongside the match vector so a same-cycle
  // row rewrite cannot leak into the stage-2 value mux.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      s1_hit_q   <= row_hit;
      s1_value_q <= row_value;
    end
  end

  always_comb begin
    found     = 1'b0;
    s2_idx_d  = '0;
    win_value = s1_value_q[0];
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (s1_hit_q[i] && !found) begin
        found     = 1'b1;
        s2_idx_d  = IDX_W'(i);
        win_value = s1_value_q[i];
      end
    end
    s2_hit_d = found;
    if (found) begin
      s2_value_d = win_value;
    end else if (MISS_MODE == MISS_HOLD) begin
      s2_value_d = held_q;
    end else begin
      s2_value_d = DEFAULT_VAL;
    end
    held_d = (s1_valid_q && found) ? win_value : held_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_hit_q   <= 1'b0;
      s2_idx_q   <= '0;
      s2_value_q <= DEFAULT_VAL;
      held_q     <= DEFAULT_VAL;
    end else begin
      s2_valid_q <= s1_valid_q;
      held_q     <= held_d;
      if (s1_valid_q) begin
        s2_hit_q   <= s2_hit_d;
        s2_idx_q   <= s2_idx_d;
        s2_value_q <= s2_value_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_hit_q   <= 1'b0;
      out_idx_q   <= '0;
      out_value_q <= DEFAULT_VAL;
    end else begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        out_hit_q   <= s2_hit_q;
        out_idx_q   <= s2_idx_q;
        out_value_q <= s2_value_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_value = out_value_q;
  assign out_hit   = out_hit_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_masked_case_lut.sv
// Bench for masked_case_lut: three configurations driven by directed and
// random stimulus, compared cycle by cycle against a behavioural table model.
`timescale 1ns/1ps
module tb_masked_case_lut;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // Group A drives d0 (hold on miss) and d1 (default 3) identically.
  logic       cfg_we_a, cfg_en_a, kmask_we_a, in_valid_a;
  logic [2:0] cfg_idx_a, cfg_value_a;
  logic [3:0] cfg_match_a, cfg_care_a, kmask_in_a, in_key_a;
  // Group B drives d2 (KEY_W 8, VAL_W 5, ENTRIES 3).
  logic       cfg_we_b, cfg_en_b, kmask_we_b, in_valid_b;
  logic [1:0] cfg_idx_b;
  logic [4:0] cfg_value_b;
  logic [7:0] cfg_match_b, cfg_care_b, kmask_in_b, in_key_b;

  logic       ov0, ov1, ov2, oh0, oh1, oh2;
  logic [2:0] oval0, oval1, oi0, oi1;
  logic [4:0] oval2;
  logic [1:0] oi2;

  masked_case_lut #(.KEY_W(4), .VAL_W(3), .ENTRIES(8), .HOLD_ON_MISS(1), .DEFAULT_VAL(3'd0)) d0 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we_a), .cfg_idx(cfg_idx_a), .cfg_en(cfg_en_a),
    .cfg_match(cfg_match_a), .cfg_care(cfg_care_a), .cfg_value(cfg_value_a),
    .kmask_we(kmask_we_a), .kmask_in(kmask_in_a), .in_valid(in_valid_a), .in_key(in_key_a),
    .out_valid(ov0), .out_value(oval0), .out_hit(oh0), .out_idx(oi0));

  masked_case_lut #(.KEY_W(4), .VAL_W(3), .ENTRIES(8), .HOLD_ON_MISS(0), .DEFAULT_VAL(3'd3)) d1 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we_a), .cfg_idx(cfg_idx_a), .cfg_en(cfg_en_a),
    .cfg_match(cfg_match_a), .cfg_care(cfg_care_a), .cfg_value(cfg_value_a),
    .kmask_we(kmask_we_a), .kmask_in(kmask_in_a), .in_valid(in_valid_a), .in_key(in_key_a),
    .out_valid(ov1), .out_value(oval1), .out_hit(oh1), .out_idx(oi1));

  masked_case_lut #(.KEY_W(8), .VAL_W(5), .ENTRIES(3), .HOLD_ON_MISS(0), .DEFAULT_VAL(5'd21)) d2 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we_b), .cfg_idx(cfg_idx_b), .cfg_en(cfg_en_b),
    .cfg_match(cfg_match_b), .cfg_care(cfg_care_b), .cfg_value(cfg_value_b),
    .kmask_we(kmask_we_b), .kmask_in(kmask_in_b), .in_valid(in_valid_b), .in_key(in_key_b),
    .out_valid(ov2), .out_value(oval2), .out_hit(oh2), .out_idx(oi2));

  localparam int KW   [3] = '{4, 4, 8};
  localparam int NE   [3] = '{8, 8, 3};
  localparam int HOLD [3] = '{1, 0, 0};
  localparam int DEF  [3] = '{0, 3, 21};

  typedef struct { int v; int val; int hit; int idx; } res_t;

  int   m_en [3][8], m_match [3][8], m_care [3][8], m_val [3][8];
  int   m_kmask [3], m_held [3];
  res_t pipe [3][2];
  int   fill [3];
  res_t exp_o [3];
  int   log_val [3][$];
  int   log_hit [3][$];
  int   log_idx [3][$];
  int   checks, errors;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      for (int r = 0; r < 8; r++) begin
        m_en[d][r] = 0; m_match[d][r] = 0; m_care[d][r] = 0; m_val[d][r] = 0;
      end
      m_kmask[d] = (1 << KW[d]) - 1;
      m_held[d]  = DEF[d];
    end
  endtask

  // First enabled row (lowest index) whose cared-for bits agree with the masked key.
  task automatic model_lookup(input int d, input int key, output res_t res);
    int k;
    k       = key & m_kmask[d];
    res.v   = 1;
    res.hit = 0;
    res.idx = 0;
    res.val = (HOLD[d] != 0) ? m_held[d] : DEF[d];
    for (int r = 0; r < NE[d]; r++) begin
      if (m_en[d][r] != 0 && ((k ^ m_match[d][r]) & m_care[d][r]) == 0) begin
        res.hit = 1; res.idx = r; res.val = m_val[d][r];
        break;
      end
    end
    if (res.hit != 0) m_held[d] = res.val;
  endtask

  task automatic cycle();
    res_t nr [3];
    int iv, key, we, idx, en, mt, cr, vl, kwe, kin;
    int gv, gval, gh, gi;
    for (int d = 0; d < 3; d++) begin
      if (d < 2) begin
        iv = int'(in_valid_a); key = int'(in_key_a); we = int'(cfg_we_a); idx = int'(cfg_idx_a);
        en = int'(cfg_en_a); mt = int'(cfg_match_a); cr = int'(cfg_care_a); vl = int'(cfg_value_a);
        kwe = int'(kmask_we_a); kin = int'(kmask_in_a);
      end else begin
        iv = int'(in_valid_b); key = int'(in_key_b); we = int'(cfg_we_b); idx = int'(cfg_idx_b);
        en = int'(cfg_en_b); mt = int'(cfg_match_b); cr = int'(cfg_care_b); vl = int'(cfg_value_b);
        kwe = int'(kmask_we_b); kin = int'(kmask_in_b);
      end
      nr[d] = '{0, 0, 0, 0};
      if (reset == 1'b0) begin
        if (iv != 0) model_lookup(d, key, nr[d]);
        if (we != 0 && idx < NE[d]) begin
          m_en[d][idx] = en; m_match[d][idx] = mt; m_care[d][idx] = cr; m_val[d][idx] = vl;
        end
        if (kwe != 0) m_kmask[d] = kin;
      end
    end
    if (reset == 1'b1) model_reset();
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      if (reset == 1'b1) begin
        fill[d]  = 0;
        exp_o[d] = '{0, DEF[d], 0, 0};
      end else begin
        exp_o[d].v = 0;
        if (fill[d] >= 2 && pipe[d][1].v != 0) exp_o[d] = pipe[d][1];
        pipe[d][1] = pipe[d][0];
        pipe[d][0] = nr[d];
        if (fill[d] < 2) fill[d]++;
      end
      case (d)
        0:       begin gv = int'(ov0); gval = int'(oval0); gh = int'(oh0); gi = int'(oi0); end
        1:       begin gv = int'(ov1); gval = int'(oval1); gh = int'(oh1); gi = int'(oi1); end
        default: begin gv = int'(ov2); gval = int'(oval2); gh = int'(oh2); gi = int'(oi2); end
      endcase
      check($sformatf("d%0d out_valid", d), gv, exp_o[d].v);
      check($sformatf("d%0d out_value", d), gval, exp_o[d].val);
      check($sformatf("d%0d out_hit", d), gh, exp_o[d].hit);
      check($sformatf("d%0d out_idx", d), gi, exp_o[d].idx);
      if (gv != 0) begin
        log_val[d].push_back(gval);
        log_hit[d].push_back(gh);
        log_idx[d].push_back(gi);
      end
    end
  endtask

  task automatic idle_inputs();
    cfg_we_a = 1'b0; cfg_en_a = 1'b0; cfg_idx_a = '0; cfg_match_a = '0; cfg_care_a = '0;
    cfg_value_a = '0; kmask_we_a = 1'b0; kmask_in_a = '0; in_valid_a = 1'b0; in_key_a = '0;
    cfg_we_b = 1'b0; cfg_en_b = 1'b0; cfg_idx_b = '0; cfg_match_b = '0; cfg_care_b = '0;
    cfg_value_b = '0; kmask_we_b = 1'b0; kmask_in_b = '0; in_valid_b = 1'b0; in_key_b = '0;
  endtask

  task automatic clear_logs();
    for (int d = 0; d < 3; d++) begin
      log_val[d].delete(); log_hit[d].delete(); log_idx[d].delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; cycle(); reset = 1'b0;
  endtask

  task automatic wr_a(input int idx, input int en, input int mt, input int cr, input int vl);
    cfg_we_a = 1'b1; cfg_idx_a = 3'(idx); cfg_en_a = 1'(en);
    cfg_match_a = 4'(mt); cfg_care_a = 4'(cr); cfg_value_a = 3'(vl);
    cycle();
    cfg_we_a = 1'b0;
  endtask

  task automatic look_a(input int key);
    in_valid_a = 1'b1; in_key_a = 4'(key); cycle(); in_valid_a = 1'b0;
  endtask

  task automatic flush();
    repeat (3) cycle();
  endtask

  initial begin
    checks = 0; errors = 0;
    reset  = 1'b1;
    idle_inputs();
    model_reset();
    for (int d = 0; d < 3; d++) fill[d] = 0;
    cycle(); cycle();
    reset = 1'b0;

    // Case-decode equivalence with latency probe.
    for (int r = 0; r < 8; r++) wr_a(r, 1, 2 * r, 15, 7 - r);
    kmask_we_a = 1'b1; kmask_in_a = 4'b1110; cycle(); kmask_we_a = 1'b0;
    in_valid_a = 1'b1; in_key_a = 4'h0; cycle(); in_valid_a = 1'b0;
    cycle();
    check("latency T+1 valid", int'(ov0), 0);
    cycle();
    check("latency T+2 valid", int'(ov0), 1);
    check("latency T+2 value", int'(oval0), 7);
    flush();
    clear_logs();
    for (int i = 0; i < 8; i++) begin
      look_a(i << 1);
      look_a((i << 1) | 1);
    end
    flush();
    check("decode count", log_val[0].size(), 16);
    for (int j = 0; j < log_val[0].size(); j++) begin
      check($sformatf("decode value %0d", j), log_val[0][j], 7 - j / 2);
      check($sformatf("decode idx %0d", j), log_idx[0][j], j / 2);
      check($sformatf("decode hit %0d", j), log_hit[0][j], 1);
    end

    // Hold versus default on a miss.
    do_reset();
    wr_a(0, 1, 0, 15, 7);
    wr_a(1, 1, 2, 15, 6);
    clear_logs();
    look_a(0); look_a(5); look_a(2); look_a(9);
    flush();
    check("hold count", log_val[0].size(), 4);
    check("default count", log_val[1].size(), 4);
    if (log_val[0].size() == 4 && log_val[1].size() == 4) begin
      check("hold v0", log_val[0][0], 7); check("hold v1", log_val[0][1], 7);
      check("hold v2", log_val[0][2], 6); check("hold v3", log_val[0][3], 6);
      check("hold h1", log_hit[0][1], 0); check("hold h2", log_hit[0][2], 1);
      check("hold h3", log_hit[0][3], 0);
      check("default v1", log_val[1][1], 3); check("default v3", log_val[1][3], 3);
      check("default v2", log_val[1][2], 6);
    end

    // Priority with a wildcard row.
    do_reset();
    wr_a(1, 1, 0, 0, 5);
    wr_a(4, 1, 4, 15, 2);
    clear_logs();
    look_a(4);
    wr_a(1, 0, 0, 0, 5);
    look_a(4);
    flush();
    check("prio count", log_val[0].size(), 2);
    if (log_val[0].size() == 2) begin
      check("prio wild value", log_val[0][0], 5); check("prio wild idx", log_idx[0][0], 1);
      check("prio exact value", log_val[0][1], 2); check("prio exact idx", log_idx[0][1], 4);
    end

    // Same-cycle row rewrite and lookup.
    do_reset();
    wr_a(0, 1, 0, 15, 7);
    clear_logs();
    cfg_we_a = 1'b1; cfg_idx_a = 3'd0; cfg_en_a = 1'b1; cfg_match_a = 4'h0; cfg_care_a = 4'hF;
    cfg_value_a = 3'd1; in_valid_a = 1'b1; in_key_a = 4'h0;
    cycle();
    cfg_we_a = 1'b0;
    cycle();
    in_valid_a = 1'b0;
    flush();
    check("collision count", log_val[0].size(), 2);
    if (log_val[0].size() == 2) begin
      check("collision old", log_val[0][0], 7);
      check("collision new", log_val[0][1], 1);
    end

    // Reset while two lookups are in flight.
    kmask_we_a = 1'b1; kmask_in_a = 4'h0; cycle(); kmask_we_a = 1'b0;
    clear_logs();
    in_valid_a = 1'b1; in_key_a = 4'h0; cycle(); cycle();
    in_valid_a = 1'b0;
    do_reset();
    cycle(); cycle();
    check("flight dropped d0", log_val[0].size(), 0);
    check("flight dropped d1", log_val[1].size(), 0);
    wr_a(0, 1, 0, 15, 5);
    look_a(1);
    flush();
    check("post reset count", log_val[1].size(), 1);
    if (log_val[1].size() == 1) begin
      check("post reset hit", log_hit[0][0], 0);
      check("post reset d0 value", log_val[0][0], 0);
      check("post reset d1 value", log_val[1][0], 3);
    end

    // Wide configuration: out-of-range row write is dropped.
    do_reset();
    clear_logs();
    cfg_we_b = 1'b1; cfg_idx_b = 2'd3; cfg_en_b = 1'b1; cfg_care_b = 8'h00; cfg_value_b = 5'd9;
    cycle();
    cfg_we_b = 1'b0;
    in_valid_b = 1'b1; in_key_b = 8'h5A; cycle(); in_valid_b = 1'b0;
    flush();
    check("idx3 ignored count", log_val[2].size(), 1);
    if (log_val[2].size() == 1) begin
      check("idx3 ignored hit", log_hit[2][0], 0);
      check("idx3 ignored value", log_val[2][0], 21);
    end

    // Random traffic on both groups.
    for (int n = 0; n < 1000; n++) begin
      reset       = ($urandom_range(0, 299) == 0);
      cfg_we_a    = ($urandom_range(0, 3) == 0);
      cfg_idx_a   = 3'($urandom_range(0, 7));
      cfg_en_a    = ($urandom_range(0, 3) != 0);
      cfg_match_a = 4'($urandom);
      cfg_care_a  = 4'($urandom) & 4'($urandom);
      cfg_value_a = 3'($urandom);
      kmask_we_a  = ($urandom_range(0, 15) == 0);
      kmask_in_a  = 4'($urandom) | 4'($urandom);
      in_valid_a  = ($urandom_range(0, 3) != 0);
      in_key_a    = 4'($urandom);
      cfg_we_b    = ($urandom_range(0, 3) == 0);
      cfg_idx_b   = 2'($urandom_range(0, 3));
      cfg_en_b    = ($urandom_range(0, 3) != 0);
      cfg_match_b = 8'($urandom);
      cfg_care_b  = 8'($urandom) & 8'($urandom) & 8'($urandom);
      cfg_value_b = 5'($urandom);
      kmask_we_b  = ($urandom_range(0, 15) == 0);
      kmask_in_b  = 8'($urandom) | 8'($urandom);
      in_valid_b  = ($urandom_range(0, 3) != 0);
      in_key_b    = 8'($urandom);
      cycle();
    end
    reset = 1'b0;
    idle_inputs();
    flush();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
